// File: rtl/multi_exchange_parser.sv
// Parses framed UART price updates: HEADER, payload, XOR checksum, FOOTER.
// Accepted frames commit all prices atomically; every outcome is a registered one-cycle pulse.
module multi_exchange_parser #(
    parameter int unsigned NUM_EXCH       = 2,
    parameter int unsigned PRICE_BYTES    = 2,
    parameter logic [7:0]  HEADER         = 8'hAA,
    parameter logic [7:0]  FOOTER         = 8'h55,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [7:0]                          rx_data,
    input  logic                                rx_valid,
    output logic [NUM_EXCH*PRICE_BYTES*8-1:0]   prices,
    output logic                                packet_valid,
    output logic                                err_checksum,
    output logic                                err_framing,
    output logic                                err_timeout,
    output logic [15:0]                         frame_count
);

    localparam int unsigned PW = 8 * PRICE_BYTES;
    localparam int unsigned NB = NUM_EXCH * PRICE_BYTES;
    localparam int unsigned TOT_W = NUM_EXCH * PW;
    localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StPayload,
        StCheck,
        StFoot
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [7:0]         xor_q, xor_d;
    logic [TOT_W-1:0]   shadow_q, shadow_d;
    logic               mismatch_q, mismatch_d;
    logic [TW-1:0]      idle_q, idle_d;
    logic [TOT_W-1:0]   prices_q, prices_d;
    logic [15:0]        frame_count_q, frame_count_d;
    logic               packet_valid_q, packet_valid_d;
    logic               err_checksum_q, err_checksum_d;
    logic               err_framing_q, err_framing_d;
    logic               err_timeout_q, err_timeout_d;
    logic               timeout;

    // Payload byte k belongs to exchange k/PRICE_BYTES and arrives MSB first.
    function automatic int unsigned slot_lsb(input int unsigned k);
        return (k / PRICE_BYTES) * PW + (PRICE_BYTES - 1 - (k % PRICE_BYTES)) * 8;
    endfunction

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        xor_d          = xor_q;
        shadow_d       = shadow_q;
        mismatch_d     = mismatch_q;
        prices_d       = prices_q;
        frame_count_d  = frame_count_q;
        packet_valid_d = 1'b0;
        err_checksum_d = 1'b0;
        err_framing_d  = 1'b0;
        err_timeout_d  = 1'b0;

        // A byte arriving on the expiry cycle wins over the timeout.
        timeout = (state_q != StIdle) && !rx_valid && (idle_q == TW'(TIMEOUT_CYCLES - 1));

        if (state_q == StIdle || rx_valid) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + TW'(1);
        end

        if (timeout) begin
            err_timeout_d = 1'b1;
            state_d       = StIdle;
            cnt_d         = '0;
            xor_d         = '0;
            shadow_d      = '0;
            mismatch_d    = 1'b0;
            idle_d        = '0;
        end else if (rx_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_data == HEADER) begin
                        state_d = StPayload;
                        cnt_d   = '0;
                        xor_d   = '0;
                    end
                end
                StPayload: begin
                    for (int unsigned k = 0; k < NB; k++) begin
                        if (cnt_q == CW'(k)) begin
                            shadow_d[slot_lsb(k) +: 8] = rx_data;
                        end
                    end
                    xor_d = xor_q ^ rx_data;
                    if (cnt_q == CW'(NB - 1)) begin
                        state_d = StCheck;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                StCheck: begin
                    mismatch_d = (rx_data != xor_q);
                    state_d    = StFoot;
                end
                StFoot: begin
                    if (rx_data != FOOTER) begin
                        err_framing_d = 1'b1;
                    end else if (mismatch_q) begin
                        err_checksum_d = 1'b1;
                    end else begin
                        packet_valid_d = 1'b1;
                        prices_d       = shadow_q;
                        frame_count_d  = frame_count_q + 16'd1;
                    end
                    state_d    = StIdle;
                    cnt_d      = '0;
                    xor_d      = '0;
                    mismatch_d = 1'b0;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            xor_q          <= '0;
            shadow_q       <= '0;
            mismatch_q     <= 1'b0;
            idle_q         <= '0;
            prices_q       <= '0;
            frame_count_q  <= '0;
            packet_valid_q <= 1'b0;
            err_checksum_q <= 1'b0;
            err_framing_q  <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            xor_q          <= xor_d;
            shadow_q       <= shadow_d;
            mismatch_q     <= mismatch_d;
            idle_q         <= idle_d;
            prices_q       <= prices_d;
            frame_count_q  <= frame_count_d;
            packet_valid_q <= packet_valid_d;
            err_checksum_q <= err_checksum_d;
            err_framing_q  <= err_framing_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    assign prices       = prices_q;
    assign packet_valid = packet_valid_q;
    assign err_checksum = err_checksum_q;
    assign err_framing  = err_framing_q;
    assign err_timeout  = err_timeout_q;
    assign frame_count  = frame_count_q;

endmodule
